prsc_period_meter: RTL and testbench
====================================

// Module: prsc_period_meter
// PURPOSE
//  Measures the period of a tick/strobe stream, such as the divided output of prscClk, in clkIn cycles.
//  - Sits on the consumer side of the prescaler in the LED cube plane datapath.
//  - Used to verify scan timing at runtime and to feed brightness/scan-rate logic.
//  - Reports each measured period with a valid/ack handshake.
//  - Flags overrun (result lost) and timeout (stream stalled).
// PARAMETERS
//  CNT_WIDTH  16  width of period counter and period_out; max measurable period 2^CNT_WIDTH-1
// PORTS
//  clkIn         in   1          system clock; all logic on rising edge
//  reset         in   1          synchronous, active-high reset
//  tickIn        in   1          strobe to measure; synchronous to clkIn; a period runs rising edge to rising edge
//  period_out    out  CNT_WIDTH  last captured period in clkIn cycles
//  period_valid  out  1          high while period_out holds an unacknowledged result
//  period_ack    in   1          consumer accept; sampled only while period_valid=1
//  overrun       out  1          sticky: a result was dropped because the previous result was not yet acked
//  timeout       out  1          sticky: no rising edge within 2^CNT_WIDTH-1 cycles
// BEHAVIOUR
//  Reset values (reset=1 at clock edge):
//  - all outputs 0; tick_d=0; cnt=0; FSM=IDLE; reset overrides all other inputs.
//  Edge detect:
//  - edge = tickIn & ~tick_d, where tick_d is tickIn registered every cycle.
//  - tickIn held high produces exactly one edge.
//  FSM IDLE:
//  - on edge: cnt<=1, go MEAS; no result is produced; timeout<=0.
//  FSM MEAS, on each cycle:
//  - no edge and cnt != all-ones: cnt<=cnt+1.
//  - no edge and cnt == all-ones: go IDLE, timeout<=1, no result.
//  - edge: result = cnt (so edges k cycles apart give period k); cnt<=1; stay MEAS.
//  Result delivery (registered):
//  - period_out/period_valid update on the clock after the edge cycle; latency 1.
//  - if period_valid=0, or period_valid=1 and period_ack=1 in the same cycle:
//    period_out<=result, period_valid<=1.
//  - if period_valid=1 and period_ack=0: result is dropped, period_out is unchanged, overrun<=1.
//  Handshake:
//  - ack with no new result: period_valid<=0 next cycle.
//  - ack while period_valid=0 is ignored.
//  - ack clears overrun (overrun<=0), unless a new drop occurs in the same cycle, in which case overrun stays 1.
//  Timeout flag:
//  - cleared only by the next edge (the IDLE->MEAS transition) or by reset.
//  - period_valid/period_out are not affected by a timeout.
//  Width and minimum period:
//  - cnt saturates via the timeout path and never wraps.
//  - minimum period is 2 (tickIn alternating every cycle).
//  Reset mid-measurement:
//  - discards the partial count and any pending result.
//  - the first edge after reset only arms the FSM (IDLE->MEAS).
// TESTING
//  1. CNT_WIDTH=16; tickIn high 1 cycle every 4.
//     -> first edge gives no valid; each later edge gives period_out=4, period_valid=1 one cycle after the edge.
//  2. tickIn toggling every cycle with ack tied high -> period_out=2 on each edge, overrun stays 0.
//  3. Period 5, ack held low for two results.
//     -> period_out stays 5 from the first result, overrun=1.
//     -> pulse ack -> period_valid=0 and overrun=0 next cycle.
//  4. ack asserted in the same cycle a new result arrives (periods 6 then 7).
//     -> period_out=7, period_valid stays 1, overrun=0.
//  5. CNT_WIDTH=4; one edge then tickIn low for 20 cycles.
//     -> timeout=1 after 15 cycles, FSM back in IDLE.
//     -> next edge clears timeout and produces no result; the following edge, 3 cycles later, gives period_out=3.
//  6. reset=1 for one cycle mid-period while period_valid=1.
//     -> all outputs 0 next cycle.
//     -> with period-4 ticks, the first valid result after reset appears at the 2nd edge, period_out=4.
//  7. tickIn held high 50 cycles from IDLE -> single edge, no result; timeout asserts at cnt all-ones.

Source files
------------

// File: rtl/prsc_period_meter.sv
// Period meter for a prescaler tick stream: counts clkIn cycles between
// rising edges of tickIn and hands each period to a consumer via valid/ack.
module prsc_period_meter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clkIn,
    input  logic                 reset,
    input  logic                 tickIn,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic                 period_valid,
    input  logic                 period_ack,
    output logic                 overrun,
    output logic                 timeout
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_MEAS = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 state;
    logic                 tick_d;
    logic [CNT_WIDTH-1:0] cnt;

    logic edge_det;
    logic cnt_max;
    logic res_vld;
    logic take_ack;
    logic accept;
    logic drop;

    assign edge_det = tickIn & ~tick_d;
    assign cnt_max  = &cnt;
    assign res_vld  = (state == ST_MEAS) & edge_det;
    assign take_ack = period_valid & period_ack;
    // A result lands if the output slot is free or is being emptied now
    assign accept   = res_vld & (~period_valid | period_ack);
    assign drop     = res_vld & period_valid & ~period_ack;

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state   <= ST_IDLE;
            tick_d  <= 1'b0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            tick_d <= tickIn;
            case (state)
                ST_IDLE: begin
                    if (edge_det) begin
                        cnt     <= CNT_ONE;
                        state   <= ST_MEAS;
                        timeout <= 1'b0;
                    end
                end
                ST_MEAS: begin
                    if (edge_det) begin
                        cnt <= CNT_ONE;
                    end else if (cnt_max) begin
                        // Stream stalled: give up rather than wrap
                        state   <= ST_IDLE;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            period_out   <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (accept) begin
                period_out   <= cnt;
                period_valid <= 1'b1;
            end else if (take_ack) begin
                period_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (take_ack) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prsc_period_meter.sv
// Bench for prsc_period_meter: a 16-bit and a 4-bit instance checked each
// cycle against a timestamp-based reference model plus directed checks.
module tb_prsc_period_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rs [2];
    logic tk [2];
    logic ak [2];

    logic [15:0] p0;
    logic        v0, o0, t0;
    logic [3:0]  p1;
    logic        v1, o1, t1;

    wire [25:0] act = {p0, v0, o0, t0, p1, v1, o1, t1};

    prsc_period_meter #(.CNT_WIDTH(16)) u16 (
        .clkIn(clk), .reset(rs[0]), .tickIn(tk[0]),
        .period_out(p0), .period_valid(v0), .period_ack(ak[0]),
        .overrun(o0), .timeout(t0)
    );

    prsc_period_meter #(.CNT_WIDTH(4)) u4 (
        .clkIn(clk), .reset(rs[1]), .tickIn(tk[1]),
        .period_out(p1), .period_valid(v1), .period_ack(ak[1]),
        .overrun(o1), .timeout(t1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: remembers the clock index of the last rising edge
    int maxv   [2] = '{65535, 15};
    bit m_arm  [2];
    int m_last [2];
    bit m_td   [2];
    int m_pout [2];
    bit m_pv   [2];
    bit m_ov   [2];
    bit m_to   [2];

    task automatic model_one(input int i);
        bit rise, have, old;
        int res;
        if (rs[i]) begin
            m_arm[i] = 0; m_td[i] = 0; m_pout[i] = 0;
            m_pv[i] = 0; m_ov[i] = 0; m_to[i] = 0;
            return;
        end
        rise = tk[i] && !m_td[i];
        m_td[i] = tk[i];
        have = 0;
        res = 0;
        if (rise) begin
            if (m_arm[i]) begin
                res = cyc - m_last[i];
                have = 1;
            end else begin
                m_arm[i] = 1;
                m_to[i] = 0;
            end
            m_last[i] = cyc;
        end else if (m_arm[i] && (cyc - m_last[i]) == maxv[i]) begin
            m_arm[i] = 0;
            m_to[i] = 1;
        end
        old = m_pv[i];
        if (have && old && !ak[i]) m_ov[i] = 1;
        else if (old && ak[i]) m_ov[i] = 0;
        if (have && (!old || ak[i])) begin
            m_pout[i] = res;
            m_pv[i] = 1;
        end else if (old && ak[i]) begin
            m_pv[i] = 0;
        end
    endtask

    function automatic logic [25:0] expv();
        logic [15:0] a;
        logic [3:0]  b;
        a = m_pout[0][15:0];
        b = m_pout[1][3:0];
        return {a, m_pv[0], m_ov[0], m_to[0], b, m_pv[1], m_ov[1], m_to[1]};
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        model_one(0);
        model_one(1);
        #1;
    endtask

    task automatic do_reset();
        rs[0] = 1; rs[1] = 1;
        tk[0] = 0; tk[1] = 0;
        ak[0] = 0; ak[1] = 0;
        step();
        rs[0] = 0; rs[1] = 0;
    endtask

    task automatic test_reset();
        rs[0] = 1; rs[1] = 1;
        tk[0] = 1; tk[1] = 1;
        ak[0] = 1; ak[1] = 1;
        step();
        step();
        total++;
        if (act !== 26'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", act, 26'h0);
        end
        total++;
        if (act !== expv()) begin
            bad++;
            $display("FAIL reset_model got=%h want=%h", act, expv());
        end
        do_reset();
    endtask

    task automatic test_period4();
        do_reset();
        for (int n = 0; n < 24; n++) begin
            tk[0] = (n % 4 == 0);
            ak[0] = 1;
            step();
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL period4 n=%0d got=%h want=%h", n, act, expv());
            end
            if (n == 0) begin
                total++;
                if (v0 !== 1'b0) begin
                    bad++;
                    $display("FAIL period4_first valid=%b want=0", v0);
                end
            end else if (n % 4 == 0) begin
                total++;
                if ({p0, v0} !== {16'd4, 1'b1}) begin
                    bad++;
                    $display("FAIL period4_val n=%0d got=%0d/%b want=4/1", n, p0, v0);
                end
            end
        end
    endtask

    task automatic test_min_period();
        do_reset();
        for (int n = 0; n < 16; n++) begin
            tk[0] = (n % 2 == 0);
            ak[0] = 1;
            step();
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL minper n=%0d got=%h want=%h", n, act, expv());
            end
            if (n >= 2 && n % 2 == 0) begin
                total++;
                if ({p0, v0, o0} !== {16'd2, 1'b1, 1'b0}) begin
                    bad++;
                    $display("FAIL minper_val n=%0d got=%0d/%b/%b want=2/1/0", n, p0, v0, o0);
                end
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        for (int n = 0; n < 14; n++) begin
            tk[0] = (n % 5 == 0);
            ak[0] = (n == 12);
            step();
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL overrun n=%0d got=%h want=%h", n, act, expv());
            end
            if (n == 11) begin
                total++;
                if ({p0, v0, o0} !== {16'd5, 1'b1, 1'b1}) begin
                    bad++;
                    $display("FAIL overrun_hold got=%0d/%b/%b want=5/1/1", p0, v0, o0);
                end
            end
            if (n == 12) begin
                total++;
                if ({v0, o0} !== 2'b00) begin
                    bad++;
                    $display("FAIL overrun_ack got=%b/%b want=0/0", v0, o0);
                end
            end
        end
    endtask

    task automatic test_ack_collide();
        do_reset();
        for (int n = 0; n < 15; n++) begin
            tk[0] = (n == 0 || n == 6 || n == 13);
            ak[0] = (n == 13);
            step();
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL collide n=%0d got=%h want=%h", n, act, expv());
            end
            if (n == 13) begin
                total++;
                if ({p0, v0, o0} !== {16'd7, 1'b1, 1'b0}) begin
                    bad++;
                    $display("FAIL collide_val got=%0d/%b/%b want=7/1/0", p0, v0, o0);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int n = 0; n < 26; n++) begin
            tk[1] = (n == 0 || n == 20 || n == 23);
            ak[1] = 0;
            step();
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL timeout n=%0d got=%h want=%h", n, act, expv());
            end
            if (n == 14 || n == 15 || n == 20) begin
                total++;
                if (t1 !== (n == 15)) begin
                    bad++;
                    $display("FAIL timeout_flag n=%0d got=%b want=%b", n, t1, n == 15);
                end
            end
            if (n == 20 || n == 23) begin
                total++;
                if ({p1, v1} !== ((n == 23) ? {4'd3, 1'b1} : 5'b0)) begin
                    bad++;
                    $display("FAIL timeout_res n=%0d got=%0d/%b", n, p1, v1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int n = 0; n < 11; n++) begin
            tk[0] = (n % 4 == 0);
            ak[0] = 0;
            rs[0] = (n == 10);
            step();
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL rstmid n=%0d got=%h want=%h", n, act, expv());
            end
        end
        total++;
        if ({p0, v0, o0, t0} !== 19'h0) begin
            bad++;
            $display("FAIL rstmid_zero got=%h want=0", {p0, v0, o0, t0});
        end
        rs[0] = 0;
        for (int m = 0; m < 12; m++) begin
            tk[0] = (m % 4 == 2);
            step();
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL rstmid_post m=%0d got=%h want=%h", m, act, expv());
            end
            if (m == 2 || m == 6) begin
                total++;
                if ({p0, v0} !== ((m == 6) ? {16'd4, 1'b1} : 17'h0)) begin
                    bad++;
                    $display("FAIL rstmid_res m=%0d got=%0d/%b", m, p0, v0);
                end
            end
        end
    endtask

    task automatic test_hold_high();
        do_reset();
        for (int n = 0; n < 50; n++) begin
            tk[0] = 1; tk[1] = 1;
            step();
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL hold n=%0d got=%h want=%h", n, act, expv());
            end
            if (n == 14 || n == 15) begin
                total++;
                if (t1 !== (n == 15)) begin
                    bad++;
                    $display("FAIL hold_to n=%0d got=%b want=%b", n, t1, n == 15);
                end
            end
        end
        total++;
        if ({v0, t0, v1, t1} !== 4'b0001) begin
            bad++;
            $display("FAIL hold_end got=%b want=0001", {v0, t0, v1, t1});
        end
    endtask

    task automatic test_random();
        int dens;
        do_reset();
        dens = 30;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) dens = ($urandom % 2 == 0) ? 30 : 3;
            rs[0] = ($urandom % 250 == 0);
            rs[1] = ($urandom % 250 == 0);
            tk[0] = ($urandom % 100 < 35);
            tk[1] = ($urandom % 100 < dens);
            ak[0] = ($urandom % 2 == 0);
            ak[1] = ($urandom % 3 == 0);
            step();
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL random n=%0d got=%h want=%h", n, act, expv());
            end
        end
        rs[0] = 0; rs[1] = 0;
    endtask

    initial begin
        rs[0] = 1; rs[1] = 1;
        tk[0] = 0; tk[1] = 0;
        ak[0] = 0; ak[1] = 0;
        test_reset();
        test_period4();
        test_min_period();
        test_overrun();
        test_ack_collide();
        test_timeout();
        test_reset_mid();
        test_hold_high();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
